// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide unit with HI/LO, fixed-latency sequencing and D-stage stall
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        Req,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] MDUout_E,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_r, lo_r, hi_n, lo_n;
  logic [31:0] hi_tmp, lo_tmp, hi_tmp_n, lo_tmp_n;
  logic        dz, dz_n;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] quo_mag, rem_mag, quo_u, rem_u;
  logic [31:0] quo_s, rem_s;

  assign prod_s = $signed({{32{A_E[31]}}, A_E}) * $signed({{32{B_E[31]}}, B_E});
  assign prod_u = {32'd0, A_E} * {32'd0, B_E};

  // Signed divide via magnitudes so -2^31 / -1 has a defined result (0x80000000 rem 0).
  assign a_mag      = A_E[31] ? (~A_E + 32'd1) : A_E;
  assign b_mag      = B_E[31] ? (~B_E + 32'd1) : B_E;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (B_E == 32'd0) ? 32'd1 : B_E;
  assign quo_mag    = a_mag / b_mag_safe;
  assign rem_mag    = a_mag % b_mag_safe;
  assign quo_s      = (A_E[31] ^ B_E[31]) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_s      = A_E[31] ? (~rem_mag + 32'd1) : rem_mag;
  assign quo_u      = A_E / b_safe;
  assign rem_u      = A_E % b_safe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      dz     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_r   <= hi_n;
      lo_r   <= lo_n;
      hi_tmp <= hi_tmp_n;
      lo_tmp <= lo_tmp_n;
      dz     <= dz_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi_r;
    lo_n     = lo_r;
    hi_tmp_n = hi_tmp;
    lo_tmp_n = lo_tmp;
    dz_n     = dz;
    case (state)
      S_IDLE: begin
        if (!Req) begin
          case (MDUOp_E)
            OP_MULT: if (start_E) begin
              hi_tmp_n = prod_s[63:32];
              lo_tmp_n = prod_s[31:0];
              dz_n     = 1'b0;
              cnt_n    = 4'(MULT_CYCLES);
              state_n  = S_RUN;
            end
            OP_MULTU: if (start_E) begin
              hi_tmp_n = prod_u[63:32];
              lo_tmp_n = prod_u[31:0];
              dz_n     = 1'b0;
              cnt_n    = 4'(MULT_CYCLES);
              state_n  = S_RUN;
            end
            OP_DIV: if (start_E) begin
              hi_tmp_n = rem_s;
              lo_tmp_n = quo_s;
              dz_n     = (B_E == 32'd0);
              cnt_n    = 4'(DIV_CYCLES);
              state_n  = S_RUN;
            end
            OP_DIVU: if (start_E) begin
              hi_tmp_n = rem_u;
              lo_tmp_n = quo_u;
              dz_n     = (B_E == 32'd0);
              cnt_n    = 4'(DIV_CYCLES);
              state_n  = S_RUN;
            end
            OP_MTHI: hi_n = A_E;
            OP_MTLO: lo_n = A_E;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = S_IDLE;
          if (!dz) begin
            hi_n = hi_tmp;
            lo_n = lo_tmp;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state == S_RUN);
  assign stall_mdu = reset & md_use_D & (start_E | busy);
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign MDUout_E  = (MDUOp_E == OP_MFHI) ? hi_r :
                     (MDUOp_E == OP_MFLO) ? lo_r : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl: vector table, corner sequences, random vs reference model
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [3:0]  MDUOp_E;
  logic [31:0] A_E, B_E;
  logic        Req;
  logic        md_use_D;
  logic        busy, stall_mdu;
  logic [31:0] MDUout_E, HI, LO;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .MDUOp_E(MDUOp_E),
    .A_E(A_E), .B_E(B_E), .Req(Req), .md_use_D(md_use_D),
    .busy(busy), .stall_mdu(stall_mdu), .MDUout_E(MDUout_E), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an operation is a pending result due at an absolute edge number.
  int          edges = 0;
  int          done  = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_dz = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output bit z);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    z = 0; h = 0; l = 0;
    case (op)
      4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      4'd2: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      4'd3: if (b == 0) z = 1; else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
      4'd4: if (b == 0) z = 1; else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic tick();
    bit          bm;
    logic [31:0] eo;
    #1;
    bm = (edges < done);
    eo = (MDUOp_E == 4'd5) ? m_hi : (MDUOp_E == 4'd6) ? m_lo : 32'd0;
    chk("stall_mdu", {31'd0, stall_mdu}, {31'd0, md_use_D & (start_E | bm)});
    chk("mdu_out", MDUout_E, eo);
    if (bm && (edges + 1 == done) && !p_dz) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (!bm && !Req) begin
      if (start_E && MDUOp_E >= 4'd1 && MDUOp_E <= 4'd4) begin
        ref_op(MDUOp_E, A_E, B_E, p_hi, p_lo, p_dz);
        done = edges + 1 + ((MDUOp_E <= 4'd2) ? 5 : 10);
      end else if (MDUOp_E == 4'd7) m_hi = A_E;
      else if (MDUOp_E == 4'd8) m_lo = A_E;
    end
    @(posedge clk);
    edges++;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, edges < done});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  task automatic idle_inputs();
    start_E = 0; MDUOp_E = 0; A_E = 0; B_E = 0; Req = 0; md_use_D = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    start_E = (op >= 4'd1 && op <= 4'd4); MDUOp_E = op; A_E = a; B_E = b; Req = rq;
    tick();
    idle_inputs();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[7];
  int   nst;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[3] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6] = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};

    idle_inputs();
    reset = 0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      int n;
      n = (vecs[i].op <= 4'd2) ? 5 : 10;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      for (int k = 0; k < n; k++) begin
        chk("vec_busy_run", {31'd0, busy}, 32'd1);
        tick();
      end
      chk("vec_busy_done", {31'd0, busy}, 32'd0);
      chk("vec_HI", HI, vecs[i].hi);
      chk("vec_LO", LO, vecs[i].lo);
    end

    // mfhi after the mult vector restored: redo mult -2*3 and read HI
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    repeat (5) tick();
    MDUOp_E = 4'd5;
    #1;
    chk("mfhi", MDUout_E, 32'hFFFFFFFF);
    tick();
    idle_inputs();

    // mult followed by mflo waiting in D: N+1 stall cycles
    start_E = 1; MDUOp_E = 4'd1; A_E = 32'd6; B_E = 32'd7; md_use_D = 1;
    nst = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_mdu) break;
      nst++;
      tick();
      start_E = 0; MDUOp_E = 0; A_E = 0; B_E = 0;
    end
    chk("stall_cycles", 32'(nst), 32'd6);
    md_use_D = 0; MDUOp_E = 4'd6;
    #1;
    chk("mflo_after_stall", MDUout_E, 32'd42);
    tick();
    idle_inputs();

    // Req blocks start and mthi
    issue(4'd1, 32'd100, 32'd100, 1'b1);
    chk("req_start_busy", {31'd0, busy}, 32'd0);
    chk("req_start_LO", LO, 32'd42);
    issue(4'd7, 32'h1234, 32'd0, 1'b1);
    chk("req_mthi_HI", HI, 32'd0);

    // divide by zero leaves HI/LO
    issue(4'd7, 32'hAA, 32'd0, 1'b0);
    issue(4'd8, 32'hBB, 32'd0, 1'b0);
    issue(4'd3, 32'd55, 32'd0, 1'b0);
    nst = 0;
    for (int i = 0; i < 40 && busy; i++) begin nst++; tick(); end
    chk("dz_busy_cycles", 32'(nst), 32'd10);
    chk("dz_HI", HI, 32'hAA);
    chk("dz_LO", LO, 32'hBB);

    // start/mt while busy are ignored
    issue(4'd1, 32'd3, 32'd5, 1'b0);
    issue(4'd3, 32'd1, 32'd1, 1'b0);
    issue(4'd7, 32'hDEAD, 32'd0, 1'b0);
    repeat (3) tick();
    chk("ignored_HI", HI, 32'd0);
    chk("ignored_LO", LO, 32'd15);

    // reset in cycle 4 of a divide
    issue(4'd4, 32'd100, 32'd3, 1'b0);
    repeat (3) tick();
    reset = 0;
    start_E = 1; MDUOp_E = 4'd5; md_use_D = 1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    chk("midrst_stall", {31'd0, stall_mdu}, 32'd0);
    chk("midrst_out", MDUout_E, 32'd0);
    idle_inputs();
    m_hi = 0; m_lo = 0; done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    issue(4'd8, 32'd5, 32'd0, 1'b0);
    chk("post_rst_mtlo", LO, 32'd5);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      MDUOp_E  = 4'($urandom_range(0, 8));
      start_E  = (MDUOp_E >= 4'd1 && MDUOp_E <= 4'd4) && ($urandom_range(0, 9) != 0);
      A_E      = $urandom;
      B_E      = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      Req      = ($urandom_range(0, 4) == 0);
      md_use_D = $urandom_range(0, 1);
      tick();
    end
    idle_inputs();
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with its sequencing controller for the five-stage MIPS pipeline. It sits in the E stage and accepts the `start_E`/`MDUOp_E` controls decoded in D. It runs mult/multu/div/divu as fixed-latency operations and owns the HI/LO registers. It generates the D-stage stall that serialises all MDU-class instructions (md, mf, mt) against an in-flight operation, and it suppresses side effects of E-stage instructions flushed by an exception or interrupt.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (range 1..15).
- `DIV_CYCLES`, 10: busy cycles for div/divu (range 1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_E`  in  1  E-stage instruction is mult/multu/div/divu.
- `MDUOp_E`  in  4  operation code: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; 0000 = none.
- `A_E`  in  32  forwarded rs value.
- `B_E`  in  32  forwarded rt value.
- `Req`  in  1  exception/interrupt taken this cycle; the E-stage instruction is flushed.
- `md_use_D`  in  1  D-stage instruction is md, mf or mt (`start_D | mf_D | mt`).
- `busy`  out  1  an operation is in flight.
- `stall_mdu`  out  1  stall the D stage (`md_use_D & (start_E | busy)`).
- `MDUout_E`  out  32  HI for mfhi, LO for mflo, otherwise 0.
- `HI`, `LO`  out  32 each  architectural HI/LO.

## Operation
- Two states: IDLE (cnt==0) and RUN (cnt!=0). `busy` = (cnt != 0).
- Accepting a start:
  - Condition: IDLE, `start_E`=1, `Req`=0.
  - Latch the result into `hi_tmp`/`lo_tmp` and load cnt with the operation's latency parameter.
  - mult: signed 64-bit product; hi_tmp = [63:32], lo_tmp = [31:0].
  - multu: unsigned 64-bit product; hi_tmp = [63:32], lo_tmp = [31:0].
  - div: signed; lo_tmp = quotient truncated toward zero, hi_tmp = remainder with the sign of the dividend.
  - divu: unsigned; lo_tmp = quotient, hi_tmp = remainder.
  - Divide by zero (`B_E`==0): the operation still runs for the full DIV_CYCLES; HI/LO are left unchanged at completion.
- RUN: cnt decrements each cycle. On the edge where cnt goes 1→0, HI←hi_tmp and LO←lo_tmp, unless the divide-by-zero flag is set.
- mthi/mtlo: in IDLE with `Req`=0, HI or LO ← `A_E` at the clock edge.
- `Req`=1 blocks all effects of the E-stage instruction: no start, no mthi/mtlo write. An operation already in RUN is not cancelled and completes normally.
- `start_E` or mt while busy is illegal, because the D stall prevents it. If it occurs anyway, it is ignored and must not disturb the in-flight operation.
- mfhi/mflo read: `MDUout_E` is combinational from the current HI/LO. The stall guarantees it is never read while busy.
- Reset (asserted low, any time, including mid-operation):
  - cnt=0, HI=LO=0, temps and the divide-by-zero flag cleared.
  - `busy`=0, `stall_mdu`=0, `MDUout_E`=0.

## Timing
- Start accepted at edge T (the end of the E cycle):
  - `busy`=1 for cycles T+1..T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new values at edge T+N and are visible in cycle T+N+1, when `busy`=0.
- `stall_mdu` covers the start cycle (via `start_E`) plus every busy cycle: N+1 cycles of D stall for a back-to-back MDU instruction.
- mthi/mtlo: the write is visible the cycle after E. No stall is needed for a following mf, since it reads in E one cycle later.
- Non-MDU instructions never stall and never see `busy`.
- Simultaneous completion (cnt 1→0) and an mt are impossible, since mt is stalled until `busy`=0.

## Test plan
- mult A=0xFFFFFFFE (-2), B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi gives 0xFFFFFFFF.
- divu A=7, B=2 → busy high 10 cycles; LO=3, HI=1. div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult, then mflo in D the next cycle → `stall_mdu` high 6 cycles; mflo then reads the correct LO.
- Start with `Req`=1 → `busy` stays 0, HI/LO unchanged. mthi 0x1234 with `Req`=1 → HI unchanged.
- div with B=0 and HI=0xAA, LO=0xBB beforehand → busy 10 cycles; HI=0xAA, LO=0xBB afterwards.
- `reset` driven low mid-divide (cycle 4 of 10) → `busy`, HI, LO go to 0 immediately; after release, new mtlo 5 gives LO=5.
